// File: rtl/stg1if_pkg.sv
// Shared types and widths for the instruction-fetch stage.
// Fetch-control states and the PC advance helper live here.
package stg1if_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  // Unsigned advance that wraps modulo 2^ADDR_W with no overflow flag.
  function automatic logic [ADDR_W-1:0] pc_step(input logic [ADDR_W-1:0] pc,
                                                input logic [ADDR_W-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/stg1if_if.sv
// Bundle of fetch-stage signals: instruction-memory req/ack port,
// downstream stall/redirect controls and the registered outputs to decode.
interface stg1if_if;
  import stg1if_pkg::*;

  logic              iw_stall;
  logic              iw_redirect;
  logic [ADDR_W-1:0] iw_redirect_pc;
  logic              ow_imem_req;
  logic [ADDR_W-1:0] ow_imem_addr;
  logic              iw_imem_ack;
  logic [DATA_W-1:0] iw_imem_data;
  logic [ADDR_W-1:0] ow_pc;
  logic [DATA_W-1:0] ow_instr;
  logic              ow_valid;

  modport master (
    input  iw_stall, iw_redirect, iw_redirect_pc, iw_imem_ack, iw_imem_data,
    output ow_imem_req, ow_imem_addr, ow_pc, ow_instr, ow_valid
  );

  modport slave (
    output iw_stall, iw_redirect, iw_redirect_pc, iw_imem_ack, iw_imem_data,
    input  ow_imem_req, ow_imem_addr, ow_pc, ow_instr, ow_valid
  );

endinterface

// File: rtl/stg1if.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time,
// buffers a word across downstream stalls and squashes fetches on redirect.
module stg1if
  import stg1if_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1),
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input logic       iw_clk,
  input logic       iw_rst,
  stg1if_if.master  bus
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] r_pc, pc_nx;
  logic [ADDR_W-1:0] r_drop_addr, drop_nx;
  logic [ADDR_W-1:0] r_hold_pc, hold_pc_nx;
  logic [DATA_W-1:0] r_hold_instr, hold_instr_nx;
  logic [ADDR_W-1:0] out_pc, out_pc_nx;
  logic [DATA_W-1:0] out_instr, out_instr_nx;
  logic              out_valid, out_valid_nx;

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state        <= S_IDLE;
      r_pc         <= RESET_PC;
      r_drop_addr  <= '0;
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
      out_pc       <= '0;
      out_instr    <= NOP_INSTR;
      out_valid    <= 1'b0;
    end else begin
      state        <= state_nx;
      r_pc         <= pc_nx;
      r_drop_addr  <= drop_nx;
      r_hold_pc    <= hold_pc_nx;
      r_hold_instr <= hold_instr_nx;
      out_pc       <= out_pc_nx;
      out_instr    <= out_instr_nx;
      out_valid    <= out_valid_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    pc_nx         = r_pc;
    drop_nx       = r_drop_addr;
    hold_pc_nx    = r_hold_pc;
    hold_instr_nx = r_hold_instr;
    out_pc_nx     = out_pc;
    out_instr_nx  = out_instr;
    out_valid_nx  = out_valid;

    unique case (state)
      S_IDLE: state_nx = S_FETCH;

      S_FETCH: begin
        if (bus.iw_redirect) begin
          // Redirect wins over stall: the wrong-path slot must become a bubble.
          pc_nx        = bus.iw_redirect_pc;
          out_valid_nx = 1'b0;
          out_instr_nx = NOP_INSTR;
          if (!bus.iw_imem_ack) begin
            drop_nx  = r_pc;
            state_nx = S_DROP;
          end
        end else if (bus.iw_imem_ack && !bus.iw_stall) begin
          out_pc_nx    = r_pc;
          out_instr_nx = bus.iw_imem_data;
          out_valid_nx = 1'b1;
          pc_nx        = pc_step(r_pc, ADDR_STEP);
        end else if (bus.iw_imem_ack) begin
          hold_pc_nx    = r_pc;
          hold_instr_nx = bus.iw_imem_data;
          state_nx      = S_HOLD;
        end else if (!bus.iw_stall) begin
          out_valid_nx = 1'b0;
          out_instr_nx = NOP_INSTR;
        end
      end

      S_HOLD: begin
        if (bus.iw_redirect) begin
          pc_nx        = bus.iw_redirect_pc;
          out_valid_nx = 1'b0;
          out_instr_nx = NOP_INSTR;
          state_nx     = S_FETCH;
        end else if (!bus.iw_stall) begin
          out_pc_nx    = r_hold_pc;
          out_instr_nx = r_hold_instr;
          out_valid_nx = 1'b1;
          pc_nx        = pc_step(r_pc, ADDR_STEP);
          state_nx     = S_FETCH;
        end
      end

      S_DROP: begin
        // The squashed request stays on the bus until memory acks it.
        if (bus.iw_redirect) pc_nx = bus.iw_redirect_pc;
        if (bus.iw_imem_ack) state_nx = S_FETCH;
        if (!bus.iw_stall) begin
          out_valid_nx = 1'b0;
          out_instr_nx = NOP_INSTR;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.ow_imem_req  = (state == S_FETCH) || (state == S_DROP);
  assign bus.ow_imem_addr = (state == S_DROP) ? r_drop_addr : r_pc;
  assign bus.ow_pc        = out_pc;
  assign bus.ow_instr     = out_instr;
  assign bus.ow_valid     = out_valid;

endmodule
